// File: rtl/capture_result_fifo.sv
`default_nettype none
// ============================================================================
// Module      : capture_result_fifo
// Description : Capture stage that sits after ComplexSequentialModule.
//               On request it samples vector_out, test_out and the three
//               logic outputs into a first-word-fall-through FIFO. A host
//               drains the FIFO through a valid/ready port. A run-control FSM
//               gates capture. If a capture arrives while the FIFO is full,
//               the FSM moves to HALT and sets a sticky overflow flag, so a
//               lost result is always reported.
// Optional    : define SIGNATURE_EN to build the 16-bit MISR over accepted
//               captures. Without it, the signature port is tied to zero.
// Ports       : clk, reset (async, active-high)
//               start/stop/clear  - run control (clear also flushes)
//               cap_valid/cap_ready, vector_out_in, test_out_in, logic_in
//               rd_valid/rd_ready/rd_data - FWFT read port
//               level, overflow, state_o, signature - status
// Revision    : 1.0 - initial release
// ============================================================================
module capture_result_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int AW     = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  clear,
    input  logic                  cap_valid,
    input  logic [DATA_W-1:0]     vector_out_in,
    input  logic [DATA_W-1:0]     test_out_in,
    input  logic [2:0]            logic_in,
    output logic                  cap_ready,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [2*DATA_W+2:0]   rd_data,
    output logic [AW:0]           level,
    output logic                  overflow,
    output logic [1:0]            state_o,
    output logic [15:0]           signature
);

    localparam logic [1:0] c_ST_IDLE = 2'b00;
    localparam logic [1:0] c_ST_RUN  = 2'b01;
    localparam logic [1:0] c_ST_HALT = 2'b10;
    localparam int         c_ENTRY_W = 2 * DATA_W + 3;

    logic [1:0]           r_state;
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [AW:0]          r_level;
    logic                 r_overflow;
    logic [c_ENTRY_W-1:0] r_mem [DEPTH];

    logic                 w_full;
    logic                 w_empty;
    logic                 w_cap_ready;
    logic                 w_wr_en;
    logic                 w_rd_en;
    logic                 w_ovf_evt;
    logic [c_ENTRY_W-1:0] w_entry;

    // Full and empty come from the occupancy count. Pointer equality cannot
    // tell a full FIFO from an empty one.
    assign w_full      = (r_level == (AW+1)'(DEPTH));
    assign w_empty     = (r_level == '0);
    assign w_cap_ready = (r_state == c_ST_RUN) && !w_full;

    // clear overrides every other request in the same cycle.
    assign w_wr_en   = !clear && cap_valid && w_cap_ready;
    assign w_rd_en   = !clear && rd_ready && !w_empty;
    assign w_ovf_evt = !clear && cap_valid && w_full && (r_state == c_ST_RUN);

    assign w_entry = {vector_out_in, test_out_in, logic_in};

    // ------------------------------------------------------------------
    // Run-control FSM and sticky overflow flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= c_ST_IDLE;
            r_overflow <= 1'b0;
        end else if (clear) begin
            r_state    <= c_ST_IDLE;
            r_overflow <= 1'b0;
        end else begin
            if (w_ovf_evt) begin
                r_overflow <= 1'b1;
            end
            case (r_state)
                c_ST_IDLE: if (start) r_state <= c_ST_RUN;
                // stop takes priority over an overflowing capture.
                c_ST_RUN: begin
                    if (stop) begin
                        r_state <= c_ST_IDLE;
                    end else if (w_ovf_evt) begin
                        r_state <= c_ST_HALT;
                    end
                end
                // HALT is left only through clear.
                c_ST_HALT: r_state <= c_ST_HALT;
                default:   r_state <= c_ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Pointers and occupancy
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_wr_en, w_rd_en})
                2'b10:   r_level <= r_level + (AW+1)'(1);
                2'b01:   r_level <= r_level - (AW+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage is not reset and is not scrubbed. The reset and clear paths
    // zero the occupancy count, so stale words are never presented.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    // ------------------------------------------------------------------
    // Optional MISR over accepted captures
    // ------------------------------------------------------------------
`ifdef SIGNATURE_EN
    logic [15:0] r_sig;
    logic [15:0] w_sig_data;

    assign w_sig_data = 16'({vector_out_in, test_out_in});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sig <= 16'hFFFF;
        end else if (clear) begin
            r_sig <= 16'hFFFF;
        end else if (w_wr_en) begin
            r_sig <= ({r_sig[14:0], 1'b0} ^ (r_sig[15] ? 16'h1021 : 16'h0000))
                     ^ w_sig_data;
        end
    end

    assign signature = r_sig;
`else
    assign signature = 16'h0000;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign cap_ready = w_cap_ready;
    assign rd_valid  = !w_empty;
    // The head entry is gated with !empty so rd_data reads zero out of reset.
    assign rd_data   = w_empty ? '0 : r_mem[r_rd_ptr];
    assign level     = r_level;
    assign overflow  = r_overflow;
    assign state_o   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_capture_result_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_capture_result_fifo
// Description : Self-checking bench for capture_result_fifo. It combines
//               directed scenarios with a randomized run. The reference
//               model is a transaction-level queue plus a run mode. A
//               separate monitor compares every word the DUT delivers
//               against the scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_capture_result_fifo;

    localparam int c_DW    = 8;
    localparam int c_DEPTH = 8;
    localparam int c_AW    = 3;
    localparam int c_IDLE  = 0;
    localparam int c_RUN   = 1;
    localparam int c_HALT  = 2;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 start = 1'b0, stop = 1'b0, clear = 1'b0;
    logic                 cap_valid = 1'b0, rd_ready = 1'b0;
    logic [c_DW-1:0]      vector_out_in = '0, test_out_in = '0;
    logic [2:0]           logic_in = '0;
    logic                 cap_ready, rd_valid, overflow;
    logic [2*c_DW+2:0]    rd_data;
    logic [c_AW:0]        level;
    logic [1:0]           state_o;
    logic [15:0]          signature;

    capture_result_fifo #(.DATA_W(c_DW), .DEPTH(c_DEPTH), .AW(c_AW)) u_dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear),
        .cap_valid(cap_valid), .vector_out_in(vector_out_in),
        .test_out_in(test_out_in), .logic_in(logic_in), .cap_ready(cap_ready),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .level(level), .overflow(overflow), .state_o(state_o),
        .signature(signature)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: queue of pending words, occupancy, mode, flags.
    logic [2*c_DW+2:0] sb_q[$];
    int                m_cnt   = 0;
    int                m_state = c_IDLE;
    bit                m_ovf   = 1'b0;
    logic [15:0]       m_sig   = 16'hFFFF;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [15:0] misr(input logic [15:0] s, input logic [15:0] d);
        logic [15:0] n;
        n = {s[14:0], 1'b0};
        if (s[15]) n = n ^ 16'h1021;
        return n ^ d;
    endfunction

    function automatic logic [15:0] exp_sig();
`ifdef SIGNATURE_EN
        return m_sig;
`else
        return 16'h0000;
`endif
    endfunction

    function automatic void check_status(input string tag);
        chk({tag, ".state"},     32'(state_o),   32'(m_state));
        chk({tag, ".level"},     32'(level),     32'(m_cnt));
        chk({tag, ".rd_valid"},  32'(rd_valid),  32'(m_cnt > 0));
        chk({tag, ".cap_ready"}, 32'(cap_ready), 32'(m_state == c_RUN && m_cnt < c_DEPTH));
        chk({tag, ".overflow"},  32'(overflow),  32'(m_ovf));
        chk({tag, ".signature"}, 32'(signature), 32'(exp_sig()));
    endfunction

    function automatic void model_reset();
        sb_q.delete();
        m_cnt   = 0;
        m_state = c_IDLE;
        m_ovf   = 1'b0;
        m_sig   = 16'hFFFF;
    endfunction

    // Monitor: mid-cycle, a word offered and accepted must match the oldest
    // word in the scoreboard. clear and reset cancel the read.
    always @(negedge clk) begin
        if (!reset && !clear && rd_valid && rd_ready) begin
            if (sb_q.size() == 0) begin
                chk("rd_data.unexpected", 32'(rd_data), 32'h7FFFFFFF);
            end else begin
                chk("rd_data", 32'(rd_data), 32'(sb_q.pop_front()));
            end
        end
    end

    // One clock cycle: apply the inputs, advance the model, check after the edge.
    task automatic step(input string tag, input logic s, input logic st,
                        input logic cl, input logic cv, input logic rr,
                        input logic [7:0] v, input logic [7:0] t,
                        input logic [2:0] lg);
        bit full_now;
        bit wr;
        bit rd;
        start = s; stop = st; clear = cl; cap_valid = cv; rd_ready = rr;
        vector_out_in = v; test_out_in = t; logic_in = lg;
        if (cl) begin
            model_reset();
        end else begin
            full_now = (m_cnt == c_DEPTH);
            wr = cv && (m_state == c_RUN) && !full_now;
            rd = rr && (m_cnt > 0);
            if (wr) begin
                sb_q.push_back({v, t, lg});
                m_sig = misr(m_sig, {v, t});
            end
            m_cnt = m_cnt + int'(wr) - int'(rd);
            if (cv && full_now && m_state == c_RUN) m_ovf = 1'b1;
            case (m_state)
                c_IDLE: if (s) m_state = c_RUN;
                c_RUN:  if (st) m_state = c_IDLE;
                        else if (cv && full_now) m_state = c_HALT;
                default: ;
            endcase
        end
        @(posedge clk);
        #1;
        start = 0; stop = 0; clear = 0; cap_valid = 0; rd_ready = 0;
        check_status(tag);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 0; stop = 0; clear = 0; cap_valid = 0; rd_ready = 0;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] v;
        logic [7:0] t;
        logic [2:0] lg;
        bit s, st, cl, cv, rr;

        // 1. Reset state and start
        do_reset();
        check_status("reset");
        step("start", 1, 0, 0, 0, 0, 0, 0, 0);

        // 2. Single write, then read
        step("wr1", 0, 0, 0, 1, 0, 8'hA5, 8'h3C, 3'b101);
        chk("wr1.rd_data", 32'(rd_data), 32'(19'b10100101_00111100_101));
        step("rd1", 0, 0, 0, 0, 1, 0, 0, 0);

        // 3. Fill, overflow into HALT, drain, clear
        for (int i = 0; i < c_DEPTH; i++)
            step("fill", 0, 0, 0, 1, 0, 8'(i * 17), 8'(~i), 3'(i));
        step("ovf", 0, 0, 0, 1, 0, 8'hEE, 8'hEE, 3'b111);
        step("halt.start", 1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < c_DEPTH; i++)
            step("drain", 0, 1, 0, 0, 1, 0, 0, 0);
        step("clear", 0, 0, 1, 0, 0, 0, 0, 0);

        // 4. Full with a simultaneous read; then a balanced read/write at level 3
        step("start4", 1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < c_DEPTH; i++)
            step("fill4", 0, 0, 0, 1, 0, 8'(i + 40), 8'(i + 90), 3'(i + 1));
        step("full.rdwr", 0, 0, 0, 1, 1, 8'h11, 8'h22, 3'b011);
        step("clear4", 0, 0, 1, 0, 1, 0, 0, 0);
        step("start4b", 1, 1, 0, 0, 0, 0, 0, 0);   // stop beats start in IDLE? no: IDLE ignores stop
        step("stop", 0, 1, 0, 0, 0, 0, 0, 0);
        step("start4c", 1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            step("fill3", 0, 0, 0, 1, 0, 8'(i + 7), 8'(i + 3), 3'(i));
        step("lvl3.rdwr", 0, 0, 0, 1, 1, 8'h5A, 8'hC3, 3'b110);
        for (int i = 0; i < 3; i++)
            step("drain3", 0, 0, 0, 0, 1, 0, 0, 0);

        // 5. Wrap with alternating write/read, then reset mid-burst
        for (int i = 0; i < 20; i++) begin
            step("wrap.wr", 0, 0, 0, 1, 0, 8'(i * 13 + 1), 8'(i * 7 + 2), 3'(i));
            step("wrap.rd", 0, 0, 0, 0, 1, 0, 0, 0);
        end
        step("burst.wr", 0, 0, 0, 1, 0, 8'h99, 8'h66, 3'b001);
        step("burst.wr2", 0, 0, 0, 1, 0, 8'h98, 8'h67, 3'b010);
        cap_valid = 1'b1;
        #2;
        reset = 1'b1;
        cap_valid = 1'b0;
        model_reset();
        #1;
        check_status("async_reset");
        do_reset();
        check_status("after_reset");

        // 6. Signature: a zero word from the reset seed, then a refused write at full
        step("start6", 1, 0, 0, 0, 0, 0, 0, 0);
        step("sig0", 0, 0, 0, 1, 0, 8'h00, 8'h00, 3'b000);
`ifdef SIGNATURE_EN
        chk("sig.EFDF", 32'(signature), 32'h0000EFDF);
`else
        chk("sig.zero", 32'(signature), 32'h00000000);
`endif
        for (int i = 1; i < c_DEPTH; i++)
            step("fill6", 0, 0, 0, 1, 0, 8'(i * 31), 8'(i * 5), 3'(i));
        step("sig.refused", 0, 0, 0, 1, 0, 8'hFF, 8'h01, 3'b111);
        step("clear6", 0, 0, 1, 0, 0, 0, 0, 0);

        // Randomized run against the model
        for (int i = 0; i < 600; i++) begin
            s  = ($urandom % 6) == 0;
            st = ($urandom % 50) == 0;
            cl = (m_state == c_HALT) ? (($urandom % 4) == 0) : (($urandom % 80) == 0);
            cv = ($urandom % 3) != 0;
            rr = ($urandom % 2) == 0;
            v  = 8'($urandom);
            t  = 8'($urandom);
            lg = 3'($urandom);
            step("rand", s, st, cl, cv, rr, v, t, lg);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
